// File: rtl/afpm_pkg.sv
// Shared types and constants for the FP16 multiplier operand transmitter.
// State set, counter width and the idle byte driven on the lanes between beats.
package afpm_pkg;

    localparam int unsigned CNT_W     = 4;
    localparam logic [7:0]  IDLE_BYTE = 8'h00;

    typedef enum logic [2:0] {
        StIdle,
        StSendLo,
        StSendHi,
        StWaitLo,
        StWaitHi,
        StDone
    } afpm_state_e;

    // A state lasting n clocks starts its down-counter at n-1 and leaves when it reaches 0.
    function automatic logic [CNT_W-1:0] cnt_load(input int unsigned cycles);
        int unsigned w_m1;
        w_m1 = (cycles == 0) ? 0 : cycles - 1;
        return w_m1[CNT_W-1:0];
    endfunction

endpackage

// File: rtl/afpm_operand_tx.sv
// Streams an FP16 operand pair to a byte-serial multiplier and, when AFPM_TX_CAPTURE_EN is
// defined, captures the two result bytes it returns; otherwise only the send phase exists.
module afpm_operand_tx
    import afpm_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES = 2,
    parameter int unsigned LAT_CYCLES  = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] op_a,
    input  logic [15:0] op_b,
    output logic [7:0]  ui_out,
    output logic [7:0]  uio_out,
    input  logic [7:0]  dut_out,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [15:0] res_data,
    output logic        busy
);

    afpm_state_e      r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [15:0]      r_a;
    logic [15:0]      r_b;
    logic             w_cnt_done;

    assign w_cnt_done = (r_cnt == '0);

`ifdef AFPM_TX_CAPTURE_EN
    logic [7:0] r_res_lo;
    logic [7:0] r_res_hi;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= StIdle;
            r_cnt    <= '0;
            r_a      <= '0;
            r_b      <= '0;
`ifdef AFPM_TX_CAPTURE_EN
            r_res_lo <= '0;
            r_res_hi <= '0;
`endif
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (in_valid) begin
                        r_a     <= op_a;
                        r_b     <= op_b;
                        r_cnt   <= cnt_load(HOLD_CYCLES);
                        r_state <= StSendLo;
                    end
                end
                StSendLo: begin
                    if (w_cnt_done) begin
                        r_cnt   <= cnt_load(HOLD_CYCLES);
                        r_state <= StSendHi;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                StSendHi: begin
                    if (w_cnt_done) begin
`ifdef AFPM_TX_CAPTURE_EN
                        r_cnt   <= cnt_load(LAT_CYCLES);
                        r_state <= StWaitLo;
`else
                        r_cnt   <= '0;
                        r_state <= StIdle;
`endif
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
`ifdef AFPM_TX_CAPTURE_EN
                StWaitLo: begin
                    if (w_cnt_done) begin
                        r_res_lo <= dut_out;
                        r_cnt    <= cnt_load(HOLD_CYCLES);
                        r_state  <= StWaitHi;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                StWaitHi: begin
                    if (w_cnt_done) begin
                        r_res_hi <= dut_out;
                        r_cnt    <= '0;
                        r_state  <= StDone;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                StDone: begin
                    if (res_ready) begin
                        r_cnt   <= '0;
                        r_state <= StIdle;
                    end
                end
`endif
                default: begin
                    r_cnt   <= '0;
                    r_state <= StIdle;
                end
            endcase
        end
    end

    // Byte-lane mux: low bytes first, then high bytes, idle byte otherwise.
    always_comb begin
        ui_out  = IDLE_BYTE;
        uio_out = IDLE_BYTE;
        if (r_state == StSendLo) begin
            ui_out  = r_a[7:0];
            uio_out = r_b[7:0];
        end else if (r_state == StSendHi) begin
            ui_out  = r_a[15:8];
            uio_out = r_b[15:8];
        end
    end

    assign in_ready = (r_state == StIdle);
    assign busy     = (r_state != StIdle);

`ifdef AFPM_TX_CAPTURE_EN
    assign res_valid = (r_state == StDone);
    assign res_data  = {r_res_hi, r_res_lo};
`else
    logic w_unused_inputs;
    assign w_unused_inputs = ^{dut_out, res_ready};
    assign res_valid       = 1'b0;
    assign res_data        = 16'h0000;
`endif

endmodule

// File: tb/tb_afpm_operand_tx.sv
// Self-checking bench for afpm_operand_tx; expectations follow AFPM_TX_CAPTURE_EN if defined.
module tb_afpm_operand_tx;

    localparam int H  = 2;
    localparam int L  = 3;
`ifdef AFPM_TX_CAPTURE_EN
    localparam int TOT = 3 * H + L;
`else
    localparam int TOT = 2 * H;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, res_valid, res_ready, busy;
    logic [15:0] op_a, op_b, res_data;
    logic [7:0]  ui_out, uio_out, dut_out;

    logic        in_valid2, in_ready2, res_valid2, res_ready2, busy2;
    logic [15:0] op_a2, op_b2, res_data2;
    logic [7:0]  ui_out2, uio_out2, dut_out2;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    afpm_operand_tx #(.HOLD_CYCLES(H), .LAT_CYCLES(L)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .op_a(op_a), .op_b(op_b), .ui_out(ui_out), .uio_out(uio_out),
        .dut_out(dut_out), .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .busy(busy)
    );

    afpm_operand_tx #(.HOLD_CYCLES(1), .LAT_CYCLES(1)) u_dut_min (
        .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2),
        .op_a(op_a2), .op_b(op_b2), .ui_out(ui_out2), .uio_out(uio_out2),
        .dut_out(dut_out2), .res_valid(res_valid2), .res_ready(res_ready2),
        .res_data(res_data2), .busy(busy2)
    );

    typedef struct {
        logic [15:0] a, b;
        logic [7:0]  dlo, dhi;
        int          bp;
        logic [7:0]  ui_lo, ui_hi, uio_lo, uio_hi;
        logic [15:0] res;
    } vec_t;

    vec_t tbl[4];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Entered in an IDLE clock; the accept edge ends it, clock k counts clocks after that edge.
    task automatic run_txn(input string tag, input logic [15:0] a, b, input logic [7:0] dlo, dhi,
                           input int bp, input bit noise, input logic [7:0] e_ui_lo, e_ui_hi,
                           input logic [7:0] e_uio_lo, e_uio_hi, input logic [15:0] e_res);
        logic [7:0] eui, euio;
        chk({tag, "/in_ready_idle"}, {15'b0, in_ready}, 16'd1);
        op_a      = a;
        op_b      = b;
        in_valid  = 1'b1;
        res_ready = 1'b0;
        for (int k = 1; k <= TOT; k++) begin
            tick();
            in_valid = noise ? 1'($urandom) : 1'b0;
            if (noise) begin
                op_a = 16'($urandom);
                op_b = 16'($urandom);
            end
            if (k <= H) begin
                eui  = e_ui_lo;
                euio = e_uio_lo;
            end else if (k <= 2 * H) begin
                eui  = e_ui_hi;
                euio = e_uio_hi;
            end else begin
                eui  = 8'h00;
                euio = 8'h00;
            end
            chk({tag, "/ui_out"}, {8'h0, ui_out}, {8'h0, eui});
            chk({tag, "/uio_out"}, {8'h0, uio_out}, {8'h0, euio});
            chk({tag, "/busy"}, {15'b0, busy}, 16'd1);
            chk({tag, "/in_ready_busy"}, {15'b0, in_ready}, 16'd0);
            chk({tag, "/res_valid_early"}, {15'b0, res_valid}, 16'd0);
            if (k == 2 * H + L) dut_out = dlo;
            else if (k == 3 * H + L) dut_out = dhi;
            else dut_out = 8'($urandom);
        end
`ifdef AFPM_TX_CAPTURE_EN
        for (int j = 0; j <= bp; j++) begin
            tick();
            chk({tag, "/res_valid"}, {15'b0, res_valid}, 16'd1);
            chk({tag, "/res_data"}, res_data, e_res);
            chk({tag, "/in_ready_done"}, {15'b0, in_ready}, 16'd0);
            chk({tag, "/ui_done"}, {8'h0, ui_out}, 16'h0);
            in_valid  = noise ? 1'($urandom) : 1'b0;
            dut_out   = 8'($urandom);
            res_ready = (j == bp);
        end
        tick();
        res_ready = 1'b0;
        in_valid  = 1'b0;
        chk({tag, "/in_ready_after"}, {15'b0, in_ready}, 16'd1);
        chk({tag, "/busy_after"}, {15'b0, busy}, 16'd0);
        chk({tag, "/res_valid_after"}, {15'b0, res_valid}, 16'd0);
`else
        tick();
        in_valid = 1'b0;
        chk({tag, "/in_ready_after"}, {15'b0, in_ready}, 16'd1);
        chk({tag, "/busy_after"}, {15'b0, busy}, 16'd0);
        chk({tag, "/res_valid_nocap"}, {15'b0, res_valid}, 16'd0);
        chk({tag, "/res_data_nocap"}, res_data, 16'h0000);
        chk({tag, "/ui_after"}, {8'h0, ui_out}, 16'h0);
`endif
    endtask

    initial begin
        logic [15:0] ra, rb;
        logic [7:0]  rlo, rhi;

        rst = 1'b1;
        in_valid = 1'b0; res_ready = 1'b0; op_a = '0; op_b = '0; dut_out = '0;
        in_valid2 = 1'b0; res_ready2 = 1'b0; op_a2 = '0; op_b2 = '0; dut_out2 = '0;
        repeat (3) tick();
        rst = 1'b0;

        chk("rst/in_ready", {15'b0, in_ready}, 16'd1);
        chk("rst/busy", {15'b0, busy}, 16'd0);
        chk("rst/res_valid", {15'b0, res_valid}, 16'd0);
        chk("rst/ui_uio", {ui_out, uio_out}, 16'h0000);
        chk("rst/res_data", res_data, 16'h0000);
        chk("rst/in_ready2", {15'b0, in_ready2}, 16'd1);

        tbl[0] = '{16'h44DF, 16'h483D, 8'hA5, 8'h3C, 0, 8'hDF, 8'h44, 8'h3D, 8'h48, 16'h3CA5};
        tbl[1] = '{16'h44DF, 16'h483D, 8'hA5, 8'h3C, 5, 8'hDF, 8'h44, 8'h3D, 8'h48, 16'h3CA5};
        tbl[2] = '{16'hFFFF, 16'h0000, 8'h00, 8'hFF, 1, 8'hFF, 8'hFF, 8'h00, 8'h00, 16'hFF00};
        tbl[3] = '{16'h1234, 16'hABCD, 8'h5A, 8'h96, 2, 8'h34, 8'h12, 8'hCD, 8'hAB, 16'h965A};
        for (int i = 0; i < 4; i++) begin
            run_txn($sformatf("vec%0d", i), tbl[i].a, tbl[i].b, tbl[i].dlo, tbl[i].dhi,
                    tbl[i].bp, 1'b0, tbl[i].ui_lo, tbl[i].ui_hi, tbl[i].uio_lo, tbl[i].uio_hi,
                    tbl[i].res);
        end

        // Randomized pairs with input noise while busy; expectations from byte slicing.
        for (int i = 0; i < 25; i++) begin
            ra  = 16'($urandom);
            rb  = 16'($urandom);
            rlo = 8'($urandom);
            rhi = 8'($urandom);
            run_txn($sformatf("rnd%0d", i), ra, rb, rlo, rhi, int'($urandom_range(0, 3)), 1'b1,
                    ra[7:0], ra[15:8], rb[7:0], rb[15:8], {rhi, rlo});
            if ($urandom_range(0, 1) == 1) tick();
        end

        // Reset in clock 3 aborts the transaction.
        op_a = 16'h44DF; op_b = 16'h483D; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("rmid/ui_c1", {8'h0, ui_out}, 16'h00DF);
        tick();
        chk("rmid/ui_c2", {8'h0, ui_out}, 16'h00DF);
        tick();
        chk("rmid/ui_c3", {8'h0, ui_out}, 16'h0044);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rmid/ui", {ui_out, uio_out}, 16'h0000);
        chk("rmid/busy", {15'b0, busy}, 16'd0);
        chk("rmid/in_ready", {15'b0, in_ready}, 16'd1);
        chk("rmid/res_valid", {15'b0, res_valid}, 16'd0);
        chk("rmid/res_data", res_data, 16'h0000);
        for (int k = 0; k < 14; k++) begin
            dut_out = 8'($urandom);
            tick();
            chk("rmid/no_result", {14'b0, res_valid, busy}, 16'd0);
        end

        // Minimum timing on the HOLD=1, LAT=1 instance.
        op_a2 = 16'h0101; op_b2 = 16'h0101; in_valid2 = 1'b1;
        tick();
        in_valid2 = 1'b0;
        chk("min/c1", {ui_out2, uio_out2}, 16'h0101);
        tick();
        chk("min/c2", {ui_out2, uio_out2}, 16'h0101);
        tick();
`ifdef AFPM_TX_CAPTURE_EN
        chk("min/c3_ui", {ui_out2, uio_out2}, 16'h0000);
        chk("min/c3_busy", {15'b0, busy2}, 16'd1);
        dut_out2 = 8'h5A;
        tick();
        chk("min/c4_valid", {15'b0, res_valid2}, 16'd0);
        dut_out2 = 8'hC3;
        tick();
        chk("min/c5_valid", {15'b0, res_valid2}, 16'd1);
        chk("min/c5_data", res_data2, 16'hC35A);
        res_ready2 = 1'b1;
        tick();
        res_ready2 = 1'b0;
        chk("min/idle_ready", {15'b0, in_ready2}, 16'd1);
        chk("min/idle_valid", {15'b0, res_valid2}, 16'd0);
`else
        chk("min/c3_ready", {15'b0, in_ready2}, 16'd1);
        chk("min/c3_busy", {15'b0, busy2}, 16'd0);
        chk("min/c3_valid", {15'b0, res_valid2}, 16'd0);
        chk("min/c3_ui", {ui_out2, uio_out2}, 16'h0000);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/afpm_operand_tx.md
AFPM_OPERAND_TX -- requirements
Module: afpm_operand_tx

Interface
REQ-001 SHALL have parameter HOLD_CYCLES, 2: clocks each byte beat is held on the outputs (legal 1..15).
REQ-002 SHALL have parameter LAT_CYCLES, 3: clocks from end of last beat to low-result-byte sample (legal 1..15).
REQ-003 SHALL have port clk  input  1  single clock, all logic on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1  operand pair offered.
REQ-006 SHALL have port in_ready  output  1  block accepts an operand pair.
REQ-007 SHALL have port op_a  input  16  FP16 operand A.
REQ-008 SHALL have port op_b  input  16  FP16 operand B.
REQ-009 SHALL have port ui_out  output  8  A byte stream to multiplier ui_in.
REQ-010 SHALL have port uio_out  output  8  B byte stream to multiplier uio_in.
REQ-011 SHALL have port dut_out  input  8  multiplier uo_out byte.
REQ-012 SHALL have port res_valid  output  1  captured 16-bit result available.
REQ-013 SHALL have port res_ready  input  1  consumer takes result.
REQ-014 SHALL have port res_data  output  16  {high byte, low byte} of result.
REQ-015 SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-016 SHALL implement states IDLE, SEND_LO, SEND_HI, WAIT_LO, WAIT_HI, DONE.
REQ-017 SHALL hold in_ready=1 only in IDLE; the cycle in which in_valid and in_ready are both high is the accept cycle; op_a/op_b are registered at the edge ending it; IDLE->SEND_LO.
REQ-018 SHALL drive ui_out=A[7:0], uio_out=B[7:0] for exactly HOLD_CYCLES clocks in SEND_LO, then A[15:8]/B[15:8] for HOLD_CYCLES clocks in SEND_HI.
REQ-019 SHALL drive ui_out=uio_out=8'h00 in every state other than SEND_LO/SEND_HI.
REQ-020 SHALL remain in WAIT_LO for LAT_CYCLES clocks and sample dut_out into res_data[7:0] on the edge ending the last WAIT_LO clock.
REQ-021 SHALL remain in WAIT_HI for HOLD_CYCLES clocks and sample dut_out into res_data[15:8] on the edge ending the last WAIT_HI clock.
REQ-022 SHALL assert res_valid in DONE; res_data stable while res_valid=1; DONE->IDLE on the edge where res_ready=1.
REQ-023 SHALL ignore op_a/op_b/in_valid changes outside the accept cycle.
REQ-024 SHALL use one down-counter, 4 bits wide, reloaded on every state entry; no state may last 0 clocks.
REQ-025 SHALL, with HOLD_CYCLES=h and LAT_CYCLES=l, give res_valid first high in clock 2h+l+h+1 after the accept edge.
REQ-026 SHALL make a new accept possible at the earliest in the clock after the DONE->IDLE edge; no overlap of transactions.

Reset
REQ-027 SHALL, when rst=1 at a rising edge, enter IDLE, zero counter, res_data and captured bytes, regardless of state; rst overrides all handshakes.
REQ-028 SHALL output after reset: in_ready=1, busy=0, res_valid=0, ui_out=uio_out=8'h00, res_data=16'h0000.
REQ-029 SHALL discard any in-flight transaction on reset mid-operation; no partial result ever appears on res_valid.

Configuration
REQ-030 SHALL, with AFPM_TX_CAPTURE_EN defined, implement WAIT_LO, WAIT_HI, DONE and the result port behaviour above.
REQ-031 SHALL, without AFPM_TX_CAPTURE_EN, go SEND_HI->IDLE directly, tie res_valid=0 and res_data=16'h0000, and ignore dut_out and res_ready.

Structure
REQ-032 SHALL place the state enumeration, the counter width constant (4) and the idle byte value (8'h00) in shared package afpm_pkg.
REQ-033 SHALL be a single module with no sub-modules; the byte-lane mux is inline.

Verification
REQ-034 SHALL cover the basic pair: HOLD=2, LAT=3, accept A=16'h44DF, B=16'h483D -> ui/uio = DF/3D in clocks 1-2, 44/48 in clocks 3-4, 00/00 from clock 5; res_valid high in clock 10.
REQ-035 SHALL cover capture: dut_out=8'hA5 in clock 7 and 8'h3C in clock 9 -> res_data=16'h3CA5 with res_valid.
REQ-036 SHALL cover back-pressure: res_ready=0 for 5 clocks after res_valid -> res_valid and res_data held, in_ready=0; res_ready=1 -> IDLE next clock, in_ready=1.
REQ-037 SHALL cover reset mid-operation: rst=1 in clock 3 -> next clock ui_out=8'h00, busy=0, res_valid=0, and no res_valid for that transaction.
REQ-038 SHALL cover the minimum timing: HOLD=1, LAT=1, A=16'h0101, B=16'h0101 -> 01/01 in clocks 1-2, res_valid in clock 5; the non-CAPTURE build returns to in_ready=1 in clock 3 with res_valid held 0.
